// File: rtl/aish_zone_scanner.sv
// Sequential 16-to-1 zone scanner: debounces each sensor zone, latches alarm
// flags and the first tripped zone, and holds the alarm until acknowledged.
module aish_zone_scanner #(
    parameter int unsigned SCAN_DIV = 4,
    parameter int unsigned DEBOUNCE = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] zone_in,
    input  logic [15:0] zone_mask,
    input  logic        arm,
    input  logic        alarm_ack,
    output logic [3:0]  sel,
    output logic        scan_done,
    output logic        alarm_valid,
    output logic [15:0] alarm_flags,
    output logic [3:0]  first_zone,
    output logic [1:0]  state
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [1:0] DEB_MAX  = 2'(DEBOUNCE);
    localparam logic [1:0] DEB_TRIP = 2'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        S_DISARMED = 2'b00,
        S_ARMED    = 2'b01,
        S_ALARM    = 2'b10
    } state_t;

    state_t           st;
    logic [DIV_W-1:0] div;
    logic [1:0]       hit [16];

    logic             step;
    logic             sample;
    logic             trip;
    logic [15:0]      zone_bit;
    logic [DIV_W-1:0] div_next;
    logic [3:0]       sel_next;

    assign state = st;

    // Step timing, sampled zone, and trip detection for the zone under sel
    always_comb begin
        step     = (div == DIV_LAST);
        sample   = zone_in[sel] & zone_mask[sel];
        trip     = step & sample & (hit[sel] == DEB_TRIP);
        zone_bit = 16'(1) << sel;
        div_next = step ? '0 : div + DIV_W'(1);
        sel_next = step ? sel + 4'd1 : sel;
    end

    // scan_done is registered one cycle early so it is high during the sel=15 step
    always_ff @(posedge clk) begin
        if (rst) begin
            div       <= '0;
            sel       <= '0;
            scan_done <= 1'b0;
        end else begin
            div       <= div_next;
            sel       <= sel_next;
            scan_done <= (div_next == DIV_LAST) && (sel_next == 4'd15);
        end
    end

    // Per-zone debounce counters run in every state; a saturated counter cannot re-trip
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) hit[i] <= 2'd0;
        end else if (step) begin
            if (!sample)               hit[sel] <= 2'd0;
            else if (hit[sel] != DEB_MAX) hit[sel] <= hit[sel] + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st          <= S_DISARMED;
            alarm_flags <= '0;
            first_zone  <= '0;
            alarm_valid <= 1'b0;
        end else begin
            case (st)
                S_DISARMED: begin
                    if (arm) st <= S_ARMED;
                end
                S_ARMED: begin
                    if (trip) begin
                        alarm_flags <= zone_bit;
                        first_zone  <= sel;
                        st          <= S_ALARM;
                        alarm_valid <= 1'b1;
                    end else if (!arm) begin
                        st <= S_DISARMED;
                    end
                end
                S_ALARM: begin
                    // Ack clears first; a same-cycle trip re-raises only while armed
                    if (alarm_ack) begin
                        if (arm && trip) begin
                            alarm_flags <= zone_bit;
                            first_zone  <= sel;
                        end else begin
                            alarm_flags <= '0;
                            first_zone  <= '0;
                            alarm_valid <= 1'b0;
                            st          <= arm ? S_ARMED : S_DISARMED;
                        end
                    end else if (trip) begin
                        alarm_flags <= alarm_flags | zone_bit;
                    end
                end
                default: begin
                    st          <= S_DISARMED;
                    alarm_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aish_zone_scanner.sv
// Self-checking bench for aish_zone_scanner: directed scenarios plus random
// traffic, all compared cycle by cycle against a behavioural model.
module tb_aish_zone_scanner;

    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DEBOUNCE = 2;
    localparam int SCAN = 16 * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] zone_in = '0;
    logic [15:0] zone_mask = 16'hFFFF;
    logic        arm = 1'b0;
    logic        alarm_ack = 1'b0;
    logic [3:0]  sel;
    logic        scan_done;
    logic        alarm_valid;
    logic [15:0] alarm_flags;
    logic [3:0]  first_zone;
    logic [1:0]  state;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: step position, per-zone hit counts, alarm status
    int          m_div = 0;
    int          m_sel = 0;
    int          m_hit [16];
    int          m_st = 0;
    logic [15:0] m_flags = '0;
    int          m_first = 0;

    aish_zone_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
        .clk(clk), .rst(rst), .zone_in(zone_in), .zone_mask(zone_mask),
        .arm(arm), .alarm_ack(alarm_ack), .sel(sel), .scan_done(scan_done),
        .alarm_valid(alarm_valid), .alarm_flags(alarm_flags),
        .first_zone(first_zone), .state(state)
    );

    always #5 clk = ~clk;

    wire [27:0] obs = {state, alarm_valid, alarm_flags, first_zone, sel, scan_done};

    function automatic logic [27:0] model_obs();
        return {2'(m_st), 1'(m_st == 2), m_flags, 4'(m_first), 4'(m_sel),
                1'((m_div == SCAN_DIV - 1) && (m_sel == 15))};
    endfunction

    task automatic model_update();
        bit stp;
        bit trp;
        bit s;
        int z;
        if (rst) begin
            m_div = 0; m_sel = 0; m_st = 0; m_flags = '0; m_first = 0;
            foreach (m_hit[i]) m_hit[i] = 0;
        end else begin
            stp = (m_div == SCAN_DIV - 1);
            trp = 1'b0;
            z   = m_sel;
            if (stp) begin
                s = zone_in[z] & zone_mask[z];
                trp = s && (m_hit[z] == DEBOUNCE - 1);
                m_hit[z] = s ? ((m_hit[z] < DEBOUNCE) ? m_hit[z] + 1 : DEBOUNCE) : 0;
                m_sel = (m_sel + 1) % 16;
            end
            m_div = (m_div + 1) % SCAN_DIV;
            if (m_st == 2 && alarm_ack) begin
                m_flags = '0; m_first = 0;
                m_st = arm ? 1 : 0;
                if (arm && trp) begin
                    m_flags[z] = 1'b1; m_first = z; m_st = 2;
                end
            end else if (m_st == 2) begin
                if (trp) m_flags[z] = 1'b1;
            end else if (m_st == 1) begin
                if (trp) begin
                    m_flags[z] = 1'b1; m_first = z; m_st = 2;
                end else if (!arm) begin
                    m_st = 0;
                end
            end else if (arm) begin
                m_st = 1;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        #1;
    endtask

    // Advance until the current cycle is the step that samples zone z
    task automatic wait_step(input int z);
        for (int k = 0; k < SCAN + 4 && !((m_div == SCAN_DIV - 1) && (m_sel == z)); k++)
            cycle();
    endtask

    // Acknowledge, arm and run one quiet scan so every hit counter is back to 0
    task automatic settle();
        alarm_ack = 1'b1; arm = 1'b1; zone_in = '0; zone_mask = 16'hFFFF;
        cycle();
        alarm_ack = 1'b0;
        repeat (SCAN + 2) cycle();
    endtask

    task automatic test_reset();
        int pulses;
        rst = 1'b1; arm = 1'b0; alarm_ack = 1'b0; zone_in = '0;
        repeat (2) cycle();
        vectors++;
        if (obs !== 28'h0) begin
            miscompares++;
            $display("FAIL reset_state observed=%h expected=%h", obs, 28'h0);
        end
        rst = 1'b0;
        pulses = 0;
        repeat (140) begin
            cycle();
            pulses += int'(scan_done);
            vectors++;
            if (obs !== model_obs()) begin
                miscompares++;
                $display("FAIL idle_scan t=%0t observed=%h expected=%h", $time, obs, model_obs());
            end
        end
        vectors++;
        if (pulses != 2 || sel !== 4'd3) begin
            miscompares++;
            $display("FAIL idle_pulses observed=%0d/sel%0d expected=2/sel3", pulses, sel);
        end
    endtask

    task automatic test_basic_trip();
        arm = 1'b1; zone_in = 16'h0020;
        repeat (2 * SCAN + 8) begin
            cycle();
            vectors++;
            if (obs !== model_obs()) begin
                miscompares++;
                $display("FAIL basic_trip t=%0t observed=%h expected=%h", $time, obs, model_obs());
            end
        end
        vectors++;
        if ({state, alarm_valid, alarm_flags, first_zone} !== {2'b10, 1'b1, 16'h0020, 4'd5}) begin
            miscompares++;
            $display("FAIL basic_trip_result observed=%b/%b/%h/%0d expected=10/1/0020/5",
                     state, alarm_valid, alarm_flags, first_zone);
        end
    endtask

    task automatic test_debounce_reject();
        settle();
        repeat (2) begin
            wait_step(7);
            zone_in = 16'h0080;
            cycle();
            zone_in = '0;
            repeat (SCAN + 4) begin
                cycle();
                vectors++;
                if (obs !== model_obs()) begin
                    miscompares++;
                    $display("FAIL debounce t=%0t observed=%h expected=%h", $time, obs, model_obs());
                end
            end
        end
        vectors++;
        if (state !== 2'b01 || alarm_flags !== 16'h0) begin
            miscompares++;
            $display("FAIL debounce_result observed=%b/%h expected=01/0000", state, alarm_flags);
        end
    endtask

    task automatic test_mask_disarm();
        settle();
        zone_mask = 16'hFFF7; zone_in = 16'h0008;
        repeat (2 * SCAN + 8) begin
            cycle();
            vectors++;
            if (obs !== model_obs()) begin
                miscompares++;
                $display("FAIL masked t=%0t observed=%h expected=%h", $time, obs, model_obs());
            end
        end
        vectors++;
        if (state !== 2'b01 || alarm_flags !== 16'h0) begin
            miscompares++;
            $display("FAIL masked_result observed=%b/%h expected=01/0000", state, alarm_flags);
        end
        zone_mask = 16'hFFFF; arm = 1'b0;
        repeat (2 * SCAN + 8) begin
            cycle();
            vectors++;
            if (obs !== model_obs()) begin
                miscompares++;
                $display("FAIL disarmed t=%0t observed=%h expected=%h", $time, obs, model_obs());
            end
        end
        vectors++;
        if (state !== 2'b00 || alarm_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL disarmed_result observed=%b/%b expected=00/0", state, alarm_valid);
        end
    endtask

    task automatic test_multi_ack();
        settle();
        wait_step(10);
        zone_in = 16'h0204;
        repeat (2 * SCAN + 8) begin
            cycle();
            vectors++;
            if (obs !== model_obs()) begin
                miscompares++;
                $display("FAIL multi_trip t=%0t observed=%h expected=%h", $time, obs, model_obs());
            end
        end
        vectors++;
        if (alarm_flags !== 16'h0204 || first_zone !== 4'd2) begin
            miscompares++;
            $display("FAIL multi_result observed=%h/%0d expected=0204/2", alarm_flags, first_zone);
        end
        alarm_ack = 1'b1;
        cycle();
        alarm_ack = 1'b0;
        vectors++;
        if ({state, alarm_valid, alarm_flags} !== {2'b01, 1'b0, 16'h0}) begin
            miscompares++;
            $display("FAIL ack_clear observed=%b/%b/%h expected=01/0/0000", state, alarm_valid, alarm_flags);
        end
        repeat (2 * SCAN + 8) begin
            cycle();
            vectors++;
            if (obs !== model_obs()) begin
                miscompares++;
                $display("FAIL no_retrip t=%0t observed=%h expected=%h", $time, obs, model_obs());
            end
        end
        vectors++;
        if (state !== 2'b01) begin
            miscompares++;
            $display("FAIL no_retrip_state observed=%b expected=01", state);
        end
        zone_in = '0;
        repeat (SCAN + 2) cycle();
        zone_in = 16'h0204;
        repeat (2 * SCAN + 8) begin
            cycle();
            vectors++;
            if (obs !== model_obs()) begin
                miscompares++;
                $display("FAIL retrip t=%0t observed=%h expected=%h", $time, obs, model_obs());
            end
        end
    endtask

    task automatic test_ack_collide();
        for (int pass = 0; pass < 2; pass++) begin
            settle();
            wait_step(13);
            zone_in = 16'h1002;
            wait_step(12);
            cycle();
            wait_step(12);
            vectors++;
            if (state !== 2'b10 || alarm_flags !== 16'h0002) begin
                miscompares++;
                $display("FAIL collide_setup observed=%b/%h expected=10/0002", state, alarm_flags);
            end
            alarm_ack = 1'b1;
            arm = (pass == 0);
            cycle();
            alarm_ack = 1'b0;
            vectors++;
            if (pass == 0 && {state, alarm_valid, alarm_flags, first_zone} !== {2'b10, 1'b1, 16'h1000, 4'd12}) begin
                miscompares++;
                $display("FAIL collide_armed observed=%b/%b/%h/%0d expected=10/1/1000/12",
                         state, alarm_valid, alarm_flags, first_zone);
            end
            if (pass == 1 && {state, alarm_valid, alarm_flags} !== {2'b00, 1'b0, 16'h0}) begin
                miscompares++;
                $display("FAIL collide_disarmed observed=%b/%b/%h expected=00/0/0000",
                         state, alarm_valid, alarm_flags);
            end
            repeat (8) begin
                cycle();
                vectors++;
                if (obs !== model_obs()) begin
                    miscompares++;
                    $display("FAIL collide t=%0t observed=%h expected=%h", $time, obs, model_obs());
                end
            end
        end
    endtask

    task automatic test_random();
        int b;
        settle();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(31) == 0) begin
                b = $urandom_range(15);
                zone_in[b] = ~zone_in[b];
            end
            if ($urandom_range(399) == 0) zone_mask = 16'($urandom) | 16'h00FF;
            if ($urandom_range(149) == 0) arm = ~arm;
            alarm_ack = ($urandom_range(39) == 0);
            rst = ($urandom_range(799) == 0);
            cycle();
            vectors++;
            if (obs !== model_obs()) begin
                miscompares++;
                $display("FAIL random t=%0t observed=%h expected=%h", $time, obs, model_obs());
            end
        end
        rst = 1'b0; alarm_ack = 1'b0;
    endtask

    initial begin
        foreach (m_hit[i]) m_hit[i] = 0;
        test_reset();
        test_basic_trip();
        test_debounce_reject();
        test_mask_disarm();
        test_multi_ack();
        test_ack_collide();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
